// File: rtl/poker_bet_settle_pkg.sv
// poker_pkg: shared types and constants for the poker bet-settlement block.
//   state_e      : round sequencer states
//   WIN_*        : winner output codes
//   CARD_MAX     : highest legal card value
//   ANTE         : chips each player antes at round start
//   PENALTY      : chips forfeited when folding a 10 (TEN_FOLD_PENALTY_EN builds)
//   card_winner  : showdown comparison helper
package poker_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ANTE   = 3'd1,
    ST_BET    = 3'd2,
    ST_SHOW   = 3'd3,
    ST_SETTLE = 3'd4,
    ST_OVER   = 3'd5
  } state_e;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_A     = 2'b01;
  localparam logic [1:0] WIN_B     = 2'b10;
  localparam logic [1:0] WIN_SPLIT = 2'b11;

  localparam int CARD_MAX = 10;
  localparam int ANTE     = 1;
  localparam int PENALTY  = 10;

  // Higher card wins; equal cards split the pot.
  function automatic logic [1:0] card_winner(input logic [7:0] card_a,
                                             input logic [7:0] card_b);
    logic [1:0] w;
    if (card_a > card_b) begin
      w = WIN_A;
    end else if (card_b > card_a) begin
      w = WIN_B;
    end else begin
      w = WIN_SPLIT;
    end
    return w;
  endfunction

endpackage

// File: rtl/poker_bet_settle_if.sv
// poker_bet_settle_if: bet-entry and status bundle between the bet counter /
// table controller (master) and the settlement block (slave).
//   master drives : start, bet_valid, bet_amt, fold, card_a, card_b
//   slave drives  : turn, min_bet, max_bet, chips_a, chips_b, pot,
//                   bet_err, round_done, winner, game_over
interface poker_bet_settle_if #(
  parameter int W  = 8,
  parameter int CW = 4
);
  logic          start;
  logic          bet_valid;
  logic [W-1:0]  bet_amt;
  logic          fold;
  logic [CW-1:0] card_a;
  logic [CW-1:0] card_b;

  logic          turn;
  logic [W-1:0]  min_bet;
  logic [W-1:0]  max_bet;
  logic [W-1:0]  chips_a;
  logic [W-1:0]  chips_b;
  logic [W-1:0]  pot;
  logic          bet_err;
  logic          round_done;
  logic [1:0]    winner;
  logic          game_over;

  modport master (
    output start, bet_valid, bet_amt, fold, card_a, card_b,
    input  turn, min_bet, max_bet, chips_a, chips_b, pot,
           bet_err, round_done, winner, game_over
  );

  modport slave (
    input  start, bet_valid, bet_amt, fold, card_a, card_b,
    output turn, min_bet, max_bet, chips_a, chips_b, pot,
           bet_err, round_done, winner, game_over
  );
endinterface

// File: rtl/poker_bet_settle_check.sv
// poker_bet_check: combinational betting rules for the player to act.
//   turn                : player to act (0=A, 1=B)
//   chips_a/b           : current stacks
//   contrib_a/b         : chips each player has put in this round
//   acted               : per-player acted flags (bit0=A, bit1=B)
//   bet_amt             : offered bet
//   min_bet / max_bet   : call amount and bet ceiling
//   legal               : bet_amt lies within [min_bet, max_bet]
//   go_show             : a legal bet_amt would close the betting round
module poker_bet_check #(
  parameter int W = 8
) (
  input  logic         turn,
  input  logic [W-1:0] chips_a,
  input  logic [W-1:0] chips_b,
  input  logic [W-1:0] contrib_a,
  input  logic [W-1:0] contrib_b,
  input  logic [1:0]   acted,
  input  logic [W-1:0] bet_amt,
  output logic [W-1:0] min_bet,
  output logic [W-1:0] max_bet,
  output logic         legal,
  output logic         go_show
);

  logic [W-1:0] own_stack_s;
  logic [W-1:0] opp_stack_s;
  logic [W-1:0] own_contrib_s;
  logic [W-1:0] opp_contrib_s;
  logic         opp_acted_s;
  logic [W-1:0] reach_s;

  // Betting limits and round-closing condition for the player to act.
  always_comb begin
    own_stack_s   = turn ? chips_b : chips_a;
    opp_stack_s   = turn ? chips_a : chips_b;
    own_contrib_s = turn ? contrib_b : contrib_a;
    opp_contrib_s = turn ? contrib_a : contrib_b;
    opp_acted_s   = turn ? acted[0] : acted[1];
    // The player to act never leads in contribution, so this cannot wrap.
    min_bet = opp_contrib_s - own_contrib_s;
    // Raising beyond what the opponent can still match is pointless.
    reach_s = min_bet + opp_stack_s;
    max_bet = (own_stack_s < reach_s) ? own_stack_s : reach_s;
    legal   = (bet_amt >= min_bet) && (bet_amt <= max_bet);
    // Paying exactly the call equalises contributions; the round closes if
    // the opponent has already acted or someone is out of chips.
    go_show = (bet_amt == min_bet) &&
              (opp_acted_s || (own_stack_s == bet_amt) ||
               (opp_stack_s == {W{1'b0}}));
  end

endmodule

// File: rtl/poker_bet_settle.sv
// poker_bet_settle: settlement end of the Indian Poker bet-entry path.
// Holds both chip stacks, the pot and turn order, validates committed bets,
// and pays out each round by fold or showdown.
//   CLK  : rising-edge clock
//   CLR  : asynchronous active-low reset
//   bus  : poker_bet_settle_if slave (bet strobes, cards, status outputs)
// Optional build macro TEN_FOLD_PENALTY_EN: folding while holding a 10 also
// costs the folder min(10, stack), paid to the winner after the pot.
module poker_bet_settle
  import poker_pkg::*;
#(
  parameter int W          = 8,
  parameter int INIT_CHIPS = 20,
  parameter int CW         = 4
) (
  input  logic           CLK,
  input  logic           CLR,
  poker_bet_settle_if.slave bus
);

  state_e       state_q, state_d;
  logic [W-1:0] chips_a_q, chips_a_d;
  logic [W-1:0] chips_b_q, chips_b_d;
  logic [W-1:0] pot_q, pot_d;
  logic [W-1:0] contrib_a_q, contrib_a_d;
  logic [W-1:0] contrib_b_q, contrib_b_d;
  logic         carry_q, carry_d;
  logic         turn_q, turn_d;
  logic         starter_q, starter_d;
  logic [1:0]   acted_q, acted_d;
  logic [1:0]   winner_q, winner_d;
  logic         bet_err_q, bet_err_d;
  logic         round_done_q, round_done_d;
  logic         game_over_q, game_over_d;
`ifdef TEN_FOLD_PENALTY_EN
  logic         pen_q, pen_d;
  logic [W-1:0] fine_s;
`endif

  logic [W-1:0] min_bet_s;
  logic [W-1:0] max_bet_s;
  logic         legal_s;
  logic         go_show_s;
  logic         bet_fire_s;
  logic [W-1:0] pay_a_s;
  logic [W-1:0] pay_b_s;

  poker_bet_check #(.W(W)) u_check (
    .turn      (turn_q),
    .chips_a   (chips_a_q),
    .chips_b   (chips_b_q),
    .contrib_a (contrib_a_q),
    .contrib_b (contrib_b_q),
    .acted     (acted_q),
    .bet_amt   (bus.bet_amt),
    .min_bet   (min_bet_s),
    .max_bet   (max_bet_s),
    .legal     (legal_s),
    .go_show   (go_show_s)
  );

  // A fold in the same cycle pre-empts any bet strobe.
  assign bet_fire_s = (state_q == ST_BET) && !bus.fold && bus.bet_valid;

  // Stacks after paying the pot (and any fold penalty) to the winner.
  always_comb begin
    pay_a_s = chips_a_q;
    pay_b_s = chips_b_q;
`ifdef TEN_FOLD_PENALTY_EN
    fine_s  = {W{1'b0}};
`endif
    case (winner_q)
      WIN_A:     pay_a_s = chips_a_q + pot_q;
      WIN_B:     pay_b_s = chips_b_q + pot_q;
      WIN_SPLIT: begin
        pay_a_s = chips_a_q + (pot_q >> 1);
        pay_b_s = chips_b_q + (pot_q >> 1);
      end
      default: begin
        pay_a_s = chips_a_q;
        pay_b_s = chips_b_q;
      end
    endcase
`ifdef TEN_FOLD_PENALTY_EN
    if (pen_q && (winner_q == WIN_A)) begin
      fine_s  = (pay_b_s < W'(PENALTY)) ? pay_b_s : W'(PENALTY);
      pay_b_s = pay_b_s - fine_s;
      pay_a_s = pay_a_s + fine_s;
    end else if (pen_q && (winner_q == WIN_B)) begin
      fine_s  = (pay_a_s < W'(PENALTY)) ? pay_a_s : W'(PENALTY);
      pay_a_s = pay_a_s - fine_s;
      pay_b_s = pay_b_s + fine_s;
    end else begin
      fine_s  = {W{1'b0}};
    end
`endif
  end

  // Round sequencer next-state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   state_d = bus.start ? ST_ANTE : ST_IDLE;
      ST_ANTE:   state_d = ST_BET;
      ST_BET: begin
        if (bus.fold) begin
          state_d = ST_SETTLE;
        end else if (bet_fire_s && legal_s && go_show_s) begin
          state_d = ST_SHOW;
        end else begin
          state_d = ST_BET;
        end
      end
      ST_SHOW:   state_d = ST_SETTLE;
      ST_SETTLE: begin
        if ((pay_a_s == {W{1'b0}}) || (pay_b_s == {W{1'b0}})) begin
          state_d = ST_OVER;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_OVER:   state_d = ST_OVER;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Datapath and registered-output next values.
  always_comb begin
    chips_a_d   = chips_a_q;
    chips_b_d   = chips_b_q;
    pot_d       = pot_q;
    contrib_a_d = contrib_a_q;
    contrib_b_d = contrib_b_q;
    carry_d     = carry_q;
    turn_d      = turn_q;
    starter_d   = starter_q;
    acted_d     = acted_q;
    winner_d    = winner_q;
    bet_err_d   = 1'b0;
`ifdef TEN_FOLD_PENALTY_EN
    pen_d       = pen_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          winner_d = WIN_NONE;
        end else begin
          winner_d = winner_q;
        end
      end
      ST_ANTE: begin
        chips_a_d   = chips_a_q - W'(ANTE);
        chips_b_d   = chips_b_q - W'(ANTE);
        contrib_a_d = W'(ANTE);
        contrib_b_d = W'(ANTE);
        // Any odd chip left over from a split rolls into this pot.
        pot_d       = W'(2 * ANTE) + W'(carry_q);
        carry_d     = 1'b0;
        turn_d      = starter_q;
        acted_d     = 2'b00;
      end
      ST_BET: begin
        if (bus.fold) begin
          winner_d = turn_q ? WIN_A : WIN_B;
`ifdef TEN_FOLD_PENALTY_EN
          pen_d = ((turn_q ? bus.card_b : bus.card_a) == CW'(CARD_MAX));
`endif
        end else if (bet_fire_s && legal_s) begin
          if (turn_q) begin
            chips_b_d   = chips_b_q - bus.bet_amt;
            contrib_b_d = contrib_b_q + bus.bet_amt;
            acted_d[1]  = 1'b1;
          end else begin
            chips_a_d   = chips_a_q - bus.bet_amt;
            contrib_a_d = contrib_a_q + bus.bet_amt;
            acted_d[0]  = 1'b1;
          end
          pot_d  = pot_q + bus.bet_amt;
          turn_d = go_show_s ? turn_q : ~turn_q;
        end else begin
          bet_err_d = bet_fire_s;
        end
      end
      ST_SHOW: begin
        winner_d = card_winner(8'(bus.card_a), 8'(bus.card_b));
`ifdef TEN_FOLD_PENALTY_EN
        pen_d    = 1'b0;
`endif
      end
      ST_SETTLE: begin
        chips_a_d = pay_a_s;
        chips_b_d = pay_b_s;
        carry_d   = (winner_q == WIN_SPLIT) ? pot_q[0] : carry_q;
        pot_d     = {W{1'b0}};
        starter_d = ~starter_q;
      end
      ST_OVER: begin
        chips_a_d = chips_a_q;
        chips_b_d = chips_b_q;
      end
      default: begin
        chips_a_d = chips_a_q;
        chips_b_d = chips_b_q;
      end
    endcase
    // These pulses line up with the state they describe.
    round_done_d = (state_d == ST_SETTLE);
    game_over_d  = (state_d == ST_OVER);
  end

  // Sequencer state register.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      chips_a_q    <= W'(INIT_CHIPS);
      chips_b_q    <= W'(INIT_CHIPS);
      pot_q        <= {W{1'b0}};
      contrib_a_q  <= {W{1'b0}};
      contrib_b_q  <= {W{1'b0}};
      carry_q      <= 1'b0;
      turn_q       <= 1'b0;
      starter_q    <= 1'b0;
      acted_q      <= 2'b00;
      winner_q     <= WIN_NONE;
      bet_err_q    <= 1'b0;
      round_done_q <= 1'b0;
      game_over_q  <= 1'b0;
`ifdef TEN_FOLD_PENALTY_EN
      pen_q        <= 1'b0;
`endif
    end else begin
      chips_a_q    <= chips_a_d;
      chips_b_q    <= chips_b_d;
      pot_q        <= pot_d;
      contrib_a_q  <= contrib_a_d;
      contrib_b_q  <= contrib_b_d;
      carry_q      <= carry_d;
      turn_q       <= turn_d;
      starter_q    <= starter_d;
      acted_q      <= acted_d;
      winner_q     <= winner_d;
      bet_err_q    <= bet_err_d;
      round_done_q <= round_done_d;
      game_over_q  <= game_over_d;
`ifdef TEN_FOLD_PENALTY_EN
      pen_q        <= pen_d;
`endif
    end
  end

  assign bus.turn       = turn_q;
  assign bus.min_bet    = min_bet_s;
  assign bus.max_bet    = max_bet_s;
  assign bus.chips_a    = chips_a_q;
  assign bus.chips_b    = chips_b_q;
  assign bus.pot        = pot_q;
  assign bus.bet_err    = bet_err_q;
  assign bus.round_done = round_done_q;
  assign bus.winner     = winner_q;
  assign bus.game_over  = game_over_q;

endmodule

// File: tb/tb_poker_bet_settle.sv
// Bench for poker_bet_settle: directed rounds with hand-computed pins, then
// randomized play, all checked every cycle against a behavioural table model.
module tb_poker_bet_settle;
  localparam int W    = 8;
  localparam int CW   = 4;
  localparam int INIT = 20;

  localparam int M_IDLE = 0, M_ANTE = 1, M_BET = 2, M_SHOW = 3, M_SETTLE = 4, M_OVER = 5;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  poker_bet_settle_if #(.W(W), .CW(CW)) bus ();

  poker_bet_settle #(.W(W), .INIT_CHIPS(INIT), .CW(CW)) dut (
    .CLK (clk),
    .CLR (clr),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Table model: plain integers, one entry per player.
  int m_phase, m_pot, m_carry, m_turn, m_starter, m_win, m_err, m_pen;
  int m_stack[2];
  int m_contrib[2];
  bit m_acted[2];

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_lo();
    return m_contrib[1 - m_turn] - m_contrib[m_turn];
  endfunction

  function automatic int m_hi();
    int reach;
    reach = m_lo() + m_stack[1 - m_turn];
    return (m_stack[m_turn] < reach) ? m_stack[m_turn] : reach;
  endfunction

  task automatic model_reset();
    m_phase = M_IDLE; m_pot = 0; m_carry = 0; m_turn = 0; m_starter = 0;
    m_win = 0; m_err = 0; m_pen = 0;
    for (int i = 0; i < 2; i++) begin
      m_stack[i] = INIT; m_contrib[i] = 0; m_acted[i] = 1'b0;
    end
  endtask

  // Advance the model by one clock using the inputs presented at that edge.
  task automatic model_step();
    int b, t, o, ca, cb, half, f, fol, wi;
    m_err = 0;
    case (m_phase)
      M_IDLE: if (bus.start) begin m_phase = M_ANTE; m_win = 0; end
      M_ANTE: begin
        for (int i = 0; i < 2; i++) begin
          m_stack[i] -= 1; m_contrib[i] = 1; m_acted[i] = 1'b0;
        end
        m_pot = 2 + m_carry; m_carry = 0; m_turn = m_starter; m_phase = M_BET;
      end
      M_BET: begin
        if (bus.fold) begin
          m_win = (m_turn == 0) ? 2 : 1;
          m_pen = 0;
`ifdef TEN_FOLD_PENALTY_EN
          m_pen = (((m_turn == 0) ? int'(bus.card_a) : int'(bus.card_b)) == 10) ? 1 : 0;
`endif
          m_phase = M_SETTLE;
        end else if (bus.bet_valid) begin
          b = int'(bus.bet_amt);
          if (b >= m_lo() && b <= m_hi()) begin
            t = m_turn; o = 1 - t;
            m_stack[t] -= b; m_contrib[t] += b; m_pot += b; m_acted[t] = 1'b1;
            if (m_contrib[t] == m_contrib[o] &&
                ((m_acted[0] && m_acted[1]) || m_stack[0] == 0 || m_stack[1] == 0))
              m_phase = M_SHOW;
            else
              m_turn = o;
          end else begin
            m_err = 1;
          end
        end
      end
      M_SHOW: begin
        ca = int'(bus.card_a); cb = int'(bus.card_b);
        m_win = (ca > cb) ? 1 : ((cb > ca) ? 2 : 3);
        m_pen = 0;
        m_phase = M_SETTLE;
      end
      M_SETTLE: begin
        if (m_win == 3) begin
          half = m_pot / 2;
          m_stack[0] += half; m_stack[1] += half; m_carry = m_pot % 2;
        end else begin
          wi = m_win - 1;
          m_stack[wi] += m_pot;
          if (m_pen != 0) begin
            fol = 1 - wi;
            f = (m_stack[fol] < 10) ? m_stack[fol] : 10;
            m_stack[fol] -= f; m_stack[wi] += f;
          end
        end
        m_pot = 0; m_starter = 1 - m_starter;
        m_phase = (m_stack[0] == 0 || m_stack[1] == 0) ? M_OVER : M_IDLE;
      end
      default: ;
    endcase
  endtask

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (clr && cmp_en) begin
      cmp("chips_a", int'(bus.chips_a), m_stack[0]);
      cmp("chips_b", int'(bus.chips_b), m_stack[1]);
      cmp("pot", int'(bus.pot), m_pot);
      cmp("turn", int'(bus.turn), m_turn);
      cmp("winner", int'(bus.winner), m_win);
      cmp("bet_err", int'(bus.bet_err), m_err);
      cmp("round_done", int'(bus.round_done), (m_phase == M_SETTLE) ? 1 : 0);
      cmp("game_over", int'(bus.game_over), (m_phase == M_OVER) ? 1 : 0);
      cmp("conservation", int'(bus.chips_a) + int'(bus.chips_b) + int'(bus.pot) + m_carry, 2 * INIT);
      if (m_phase == M_BET) begin
        cmp("min_bet", int'(bus.min_bet), m_lo());
        cmp("max_bet", int'(bus.max_bet), m_hi());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    bus.start = 1'b0; bus.bet_valid = 1'b0; bus.bet_amt = '0; bus.fold = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    clr = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    clr = 1'b1;
  endtask

  task automatic start_round();
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    tick();
  endtask

  task automatic bet(input int b);
    bus.bet_valid = 1'b1; bus.bet_amt = W'(b); tick(); bus.bet_valid = 1'b0;
  endtask

  task automatic cards(input int a, input int b);
    bus.card_a = CW'(a); bus.card_b = CW'(b);
  endtask

  task automatic pin3(input string name, input int a, input int b, input int p);
    cmp({name, "_chips_a"}, int'(bus.chips_a), a);
    cmp({name, "_chips_b"}, int'(bus.chips_b), b);
    cmp({name, "_pot"}, int'(bus.pot), p);
    cmp({name, "_model_a"}, m_stack[0], a);
  endtask

  int over_cnt;
  int r, lo, hi;

  initial begin
    clr = 1'b0;
    idle_inputs();
    cards(1, 1);
    model_reset();
    repeat (2) @(negedge clk);
    cmp("rst_chips_a", int'(bus.chips_a), INIT);
    cmp("rst_pot", int'(bus.pot), 0);
    cmp("rst_winner", int'(bus.winner), 0);
    clr = 1'b1;
    cmp_en = 1'b1;

    // 1: A bets 3, B calls 3, A shows 7 over 4.
    start_round();
    pin3("t1_ante", 19, 19, 2);
    bet(3); bet(3);
    pin3("t1_bets", 16, 16, 8);
    cards(7, 4); tick();
    cmp("t1_round_done", int'(bus.round_done), 1);
    cmp("t1_winner", int'(bus.winner), 1);
    tick();
    pin3("t1_paid", 24, 16, 0);
    cmp("t1_round_done_low", int'(bus.round_done), 0);

    // 2: checks then even split; then B opens 1, A calls, split again.
    do_reset();
    start_round(); bet(0); bet(0);
    cards(5, 5); tick(); tick();
    pin3("t2_split", 20, 20, 0);
    cmp("t2_winner", int'(bus.winner), 3);
    start_round();
    cmp("t2_turn_b", int'(bus.turn), 1);
    bet(1); bet(1);
    pin3("t2_bets", 18, 18, 4);
    cards(6, 6); tick(); tick();
    pin3("t2_split2", 20, 20, 0);

    // 3: over max and under min are rejected without state change.
    do_reset();
    start_round();
    bet(25);
    cmp("t3_err_hi", int'(bus.bet_err), 1);
    pin3("t3_hi", 19, 19, 2);
    tick();
    cmp("t3_err_clear", int'(bus.bet_err), 0);
    bet(3); bet(1);
    cmp("t3_err_lo", int'(bus.bet_err), 1);
    cards(3, 3);
    bus.fold = 1'b1; tick(); bus.fold = 1'b0;
    tick();
    pin3("t3_fold", 21, 19, 0);

    // 4: fold together with a bet strobe; fold wins, no error.
    start_round();
    bus.fold = 1'b1; bus.bet_valid = 1'b1; bus.bet_amt = 8'd5; tick();
    idle_inputs();
    cmp("t4_no_err", int'(bus.bet_err), 0);
    cmp("t4_winner", int'(bus.winner), 1);
    tick();
    pin3("t4_paid", 22, 18, 0);

    // 5: all-in and call; A loses everything; start then ignored.
    do_reset();
    start_round();
    cmp("t5_max", int'(bus.max_bet), 19);
    bet(19); bet(19);
    cards(2, 9); tick(); tick();
    cmp("t5_game_over", int'(bus.game_over), 1);
    pin3("t5_over", 0, 40, 0);
    bus.start = 1'b1; tick(); bus.start = 1'b0; tick();
    cmp("t5_sticky", int'(bus.game_over), 1);

    // 6: reset mid-bet discards the pot immediately.
    do_reset();
    start_round(); bet(7);
    pin3("t6_pre", 12, 19, 9);
    clr = 1'b0;
    #1;
    cmp("t6_rst_a", int'(bus.chips_a), 20);
    cmp("t6_rst_pot", int'(bus.pot), 0);
    model_reset();
    @(negedge clk);
    clr = 1'b1;

`ifdef TEN_FOLD_PENALTY_EN
    start_round();
    cards(10, 4);
    bus.fold = 1'b1; tick(); bus.fold = 1'b0;
    tick();
    pin3("t6_penalty", 9, 31, 0);
    do_reset();
`endif

    // Randomized play.
    over_cnt = 0;
    for (int n = 0; n < 6000; n++) begin
      idle_inputs();
      cards($urandom_range(1, 10), $urandom_range(1, 10));
      r = $urandom_range(0, 99);
      case (m_phase)
        M_IDLE: bus.start = (r < 30);
        M_BET: begin
          lo = m_lo(); hi = m_hi();
          if (r < 7) begin
            bus.fold = 1'b1;
          end else if (r < 10) begin
            bus.fold = 1'b1; bus.bet_valid = 1'b1; bus.bet_amt = W'($urandom_range(0, 255));
          end else if (r < 20) begin
            bus.bet_valid = 1'b1; bus.bet_amt = W'($urandom_range(0, 40));
          end else if (r < 55) begin
            bus.bet_valid = 1'b1; bus.bet_amt = W'(lo);
          end else if (r < 85) begin
            bus.bet_valid = 1'b1; bus.bet_amt = W'(lo + $urandom_range(0, hi - lo));
          end else begin
            bus.bet_valid = 1'b0;
          end
        end
        default: begin
          bus.start = (r < 10);
          bus.bet_valid = (r > 90);
          bus.fold = (r > 95);
        end
      endcase
      if (m_phase == M_OVER) over_cnt++;
      if (over_cnt > 4 || $urandom_range(0, 599) == 0) begin
        over_cnt = 0;
        do_reset();
      end else begin
        tick();
      end
    end

    idle_inputs();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
